// File: rtl/visor_trace_uart_pkg.sv
// Shared definitions for the visor trace UART.
//   TRACE_ADDR_WORD / TRACE_ADDR_BYTE : av_address[1:0] decode values
//   tx_state_e                         : transmit state machine encoding
//   trace_entry_t                      : one FIFO entry, {is_word, data}
//   trace_targets_fifo()               : true for addresses that enqueue
package visor_trace_uart_pkg;

    localparam logic [1:0] TRACE_ADDR_WORD = 2'd0;
    localparam logic [1:0] TRACE_ADDR_BYTE = 2'd1;

    localparam int unsigned TRACE_ENTRY_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    typedef struct packed {
        logic        is_word;
        logic [15:0] data;
    } trace_entry_t;

    function automatic logic trace_targets_fifo(input logic [1:0] addr);
        return (addr == TRACE_ADDR_WORD) || (addr == TRACE_ADDR_BYTE);
    endfunction

endpackage

// File: rtl/visor_trace_uart_if.sv
// Avalon-MM write-only slave bundle between the visor master and the trace UART.
//   av_address     : word address, only [1:0] decoded by the slave
//   av_writedata   : write data
//   av_write       : write strobe
//   av_waitrequest : slave stall; master holds all av_* while it is high
interface visor_trace_uart_if;

    logic [15:0] av_address;
    logic [15:0] av_writedata;
    logic        av_write;
    logic        av_waitrequest;

    modport master (
        output av_address,
        output av_writedata,
        output av_write,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_writedata,
        input  av_write,
        output av_waitrequest
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO for trace entries.
//   clk, rst : clock, synchronous active-high reset (clears pointers/count)
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry, valid whenever empty is low
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupied entries, 0..DEPTH
module trace_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/visor_trace_uart.sv
// Visor trace UART: Avalon-MM writes are queued as byte or word entries and
// shifted out on an 8N1 serial line, LSB first, idle high.
//   sysclk, sysreset : clock, synchronous active-high reset
//   av               : Avalon-MM slave (address, writedata, write, waitrequest)
//   uart_tx          : serial output (registered)
//   fifo_count       : occupied FIFO entries
//   tx_busy          : frame on the line or FIFO non-empty
module visor_trace_uart
    import visor_trace_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic               sysclk,
    input  logic               sysreset,
    visor_trace_uart_if.slave  av,
    output logic               uart_tx,
    output logic [8:0]         fifo_count,
    output logic               tx_busy
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Avalon decode
    logic              targets_fifo;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_cnt;
    trace_entry_t      push_entry;
    trace_entry_t      head_entry;
    logic              unused_addr_bits;

    assign targets_fifo     = trace_targets_fifo(av.av_address[1:0]);
    assign unused_addr_bits = ^av.av_address[15:2];

    // Stall only writes that would enqueue; addresses 2/3 always complete.
    assign av.av_waitrequest = av.av_write & fifo_full & targets_fifo & ~sysreset;
    assign fifo_push         = av.av_write & ~av.av_waitrequest & targets_fifo;

    assign push_entry.is_word = (av.av_address[1:0] == TRACE_ADDR_WORD);
    assign push_entry.data    = av.av_writedata;

    // Transmit state
    tx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [7:0]        lo_byte_q;
    logic              lo_pend_q;
    logic              tx_q;
    logic              bit_end;

    assign bit_end  = (cnt_q == BIT_LAST);
    assign fifo_pop = (state_q == IDLE) & ~fifo_empty;

    trace_fifo #(
        .WIDTH (TRACE_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (sysreset),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // uart_tx is registered alongside the state so each line level lines up
    // exactly with its state's CLKS_PER_BIT-cycle window.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            lo_byte_q <= '0;
            lo_pend_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            if (state_q != IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        lo_pend_q <= head_entry.is_word;
                        lo_byte_q <= head_entry.data[7:0];
                        shift_q   <= head_entry.is_word ? head_entry.data[15:8]
                                                        : head_entry.data[7:0];
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        // Low byte of a word follows its high byte with no idle gap.
                        if (lo_pend_q) begin
                            state_q   <= START;
                            tx_q      <= 1'b0;
                            shift_q   <= lo_byte_q;
                            lo_pend_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign fifo_count = 9'(fifo_cnt);
    assign tx_busy    = (state_q != IDLE) | (fifo_cnt != '0);

endmodule

// File: tb/tb_visor_trace_uart.sv
`timescale 1ns/1ps
module tb_visor_trace_uart;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic       sysclk   = 1'b0;
    logic       sysreset = 1'b1;
    logic       uart_tx;
    logic       tx_busy;
    logic [8:0] fifo_count;

    visor_trace_uart_if av();

    visor_trace_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .sysclk     (sysclk),
        .sysreset   (sysreset),
        .av         (av),
        .uart_tx    (uart_tx),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] b;
        int         start;
        logic       ok;
    } frame_t;

    frame_t frames[$];

    // Line decoder: samples one cycle after each edge, bits at mid-period.
    initial begin : monitor
        frame_t f;
        bit     aborted;
        forever begin
            @(posedge sysclk); #1;
            if (sysreset !== 1'b1 && uart_tx === 1'b0) begin
                f.start = cyc;
                f.b     = '0;
                f.ok    = 1'b1;
                aborted = 1'b0;
                for (int k = 1; k <= 39; k++) begin
                    @(posedge sysclk); #1;
                    if (sysreset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k == 2 && uart_tx !== 1'b0) f.ok = 1'b0;
                    if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) f.b[(k - 6) / 4] = uart_tx;
                    if (k == 38 && uart_tx !== 1'b1) f.ok = 1'b0;
                end
                if (!aborted) frames.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge sysclk); #2;
    endtask

    task automatic wait_until(input int target);
        int g = 0;
        while (cyc < target && g < 5000) begin
            step();
            g++;
        end
    endtask

    task automatic av_wr(input logic [15:0] a, input logic [15:0] d, output int waits);
        waits = 0;
        av.av_address   = a;
        av.av_writedata = d;
        av.av_write     = 1'b1;
        #1;
        while (av.av_waitrequest === 1'b1 && waits < 500) begin
            step();
            waits++;
        end
        if (waits >= 500) begin
            n_total++;
            $display("FAIL wr_timeout: waitrequest still 1 after %0d cycles, need 0", waits);
        end
        step();
        av.av_write = 1'b0;
    endtask

    task automatic get_frame(output frame_t f);
        int t = 0;
        while (frames.size() == 0 && t < 200) begin
            step();
            t++;
        end
        if (frames.size() == 0) begin
            n_total++;
            $display("FAIL frame_timeout: got no frame in %0d cycles, need one", t);
            f.b = 'x;
            f.start = -1000;
            f.ok = 1'b0;
        end else begin
            f = frames.pop_front();
        end
    endtask

    task automatic expect_frame(input string nm, input logic [7:0] eb, output frame_t f);
        get_frame(f);
        if (f.start != -1000) begin
            chk(nm, 32'(f.b), 32'(eb));
            chk({nm, "_framing"}, 32'(f.ok), 1);
        end
    endtask

    task automatic end_of_tx(input string nm, input frame_t last);
        if (last.start == -1000) begin
            // timeout already reported
        end else if (cyc <= last.start + FRAME - 1) begin
            wait_until(last.start + FRAME - 1);
            chk({nm, "_busy_in_stop"}, 32'(tx_busy), 1);
            chk({nm, "_tx_in_stop"}, 32'(uart_tx), 1);
            step();
            chk({nm, "_busy_after_stop"}, 32'(tx_busy), 0);
            chk({nm, "_tx_idle"}, 32'(uart_tx), 1);
            chk({nm, "_count_empty"}, 32'(fifo_count), 0);
        end else begin
            n_total++;
            $display("FAIL %s_late: at cycle %0d, need <= %0d", nm, cyc, last.start + FRAME - 1);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          nfr;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    initial begin : main
        vec_t       vecs[6];
        frame_t     f0, f1, last;
        int         w, acc;
        logic [7:0] exp_bytes[$];

        vecs[0] = '{16'h0000, 16'hA55A, 2, 8'hA5, 8'h5A};
        vecs[1] = '{16'h0001, 16'h1234, 1, 8'h34, 8'h00};
        vecs[2] = '{16'h0004, 16'h8001, 2, 8'h80, 8'h01};
        vecs[3] = '{16'h0005, 16'hAB0F, 1, 8'h0F, 8'h00};
        vecs[4] = '{16'h0002, 16'hBEEF, 0, 8'h00, 8'h00};
        vecs[5] = '{16'h0003, 16'hCAFE, 0, 8'h00, 8'h00};

        av.av_address   = '0;
        av.av_writedata = '0;
        av.av_write     = 1'b0;
        sysreset        = 1'b1;
        repeat (3) step();
        chk("rst_uart_tx", 32'(uart_tx), 1);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_waitrequest", 32'(av.av_waitrequest), 0);
        sysreset = 1'b0;
        step();

        // Single writes, one per table row
        for (int i = 0; i < 6; i++) begin
            av_wr(vecs[i].addr, vecs[i].data, w);
            acc = cyc;
            chk("vec_nowait", 32'(w), 0);
            chk("vec_count_after_wr", 32'(fifo_count), 32'(vecs[i].nfr != 0));
            chk("vec_tx_high_in_pop", 32'(uart_tx), 1);
            chk("vec_busy_after_wr", 32'(tx_busy), 32'(vecs[i].nfr != 0));
            if (vecs[i].nfr == 0) begin
                repeat (4) step();
                chk("vec_noop_busy", 32'(tx_busy), 0);
                chk("vec_noop_count", 32'(fifo_count), 0);
                chk("vec_noop_no_frame", 32'(frames.size()), 0);
            end else begin
                expect_frame("vec_byte0", vecs[i].b0, f0);
                chk("vec_start_latency", 32'(f0.start - acc), 1);
                last = f0;
                if (vecs[i].nfr == 2) begin
                    expect_frame("vec_byte1", vecs[i].b1, f1);
                    chk("vec_b2b_gap", 32'(f1.start - f0.start), 32'(FRAME));
                    last = f1;
                end
                end_of_tx("vec", last);
            end
        end

        // Backpressure: byte keeps the line busy, four words fill the FIFO,
        // addr 2 / 0xFFFF pass through, fifth word stalls until the first pop.
        av_wr(16'h0001, 16'h0077, w);
        acc = cyc;
        av_wr(16'h0000, 16'h0102, w);
        av_wr(16'h0000, 16'h0304, w);
        av_wr(16'h0000, 16'h0506, w);
        av_wr(16'h0000, 16'h0708, w);
        chk("full_count", 32'(fifo_count), 4);
        av_wr(16'h0002, 16'hDEAD, w);
        chk("addr2_nowait", 32'(w), 0);
        chk("addr2_count", 32'(fifo_count), 4);
        av_wr(16'hFFFF, 16'hBEEF, w);
        chk("addrffff_nowait", 32'(w), 0);
        chk("addrffff_count", 32'(fifo_count), 4);
        av_wr(16'h0000, 16'h090A, w);
        chk("fifth_stall_cycles", 32'(w), 36);
        chk("fifth_accept_cycle", 32'(cyc - acc), 43);
        chk("fifth_count", 32'(fifo_count), 4);
        exp_bytes = '{8'h77, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                      8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        for (int j = 0; j < 11; j++) begin
            expect_frame("bp_byte", exp_bytes[j], f1);
            if (j > 0 && f1.start != -1000 && last.start != -1000) begin
                // hi byte of a new entry follows one pop cycle; lo byte is back-to-back
                chk("bp_gap", 32'(f1.start - last.start), (j % 2 == 1) ? 32'(FRAME + 1) : 32'(FRAME));
            end
            last = f1;
        end
        end_of_tx("bp", last);

        // Push and pop on the same edge with two entries queued
        av_wr(16'h0001, 16'h0011, w);
        acc = cyc;
        av_wr(16'h0000, 16'h2233, w);
        av_wr(16'h0000, 16'h4455, w);
        chk("pp_count_two", 32'(fifo_count), 2);
        wait_until(acc + FRAME + 1);
        chk("pp_count_before", 32'(fifo_count), 2);
        av_wr(16'h0000, 16'h6677, w);
        chk("pp_nowait", 32'(w), 0);
        chk("pp_count_after", 32'(fifo_count), 2);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        foreach (exp_bytes[j]) begin
            expect_frame("pp_byte", exp_bytes[j], f1);
            last = f1;
        end
        end_of_tx("pp", last);

        // Reset during data bit 2 of a frame, with the FIFO full
        av_wr(16'h0001, 16'h003A, w);
        acc = cyc;
        av_wr(16'h0000, 16'h1111, w);
        av_wr(16'h0000, 16'h2222, w);
        av_wr(16'h0000, 16'h3333, w);
        av_wr(16'h0000, 16'h4444, w);
        wait_until(acc + 14);
        chk("rst_mid_bit2_level", 32'(uart_tx), 0);
        chk("rst_mid_count_full", 32'(fifo_count), 4);
        av.av_address   = 16'h0000;
        av.av_writedata = 16'hFFFF;
        av.av_write     = 1'b1;
        #1;
        chk("rst_mid_wr_stalled", 32'(av.av_waitrequest), 1);
        sysreset = 1'b1;
        #1;
        chk("rst_mid_wr_released", 32'(av.av_waitrequest), 0);
        step();
        av.av_write = 1'b0;
        sysreset    = 1'b0;
        chk("rst_mid_tx", 32'(uart_tx), 1);
        chk("rst_mid_count", 32'(fifo_count), 0);
        chk("rst_mid_busy", 32'(tx_busy), 0);
        wait_until(cyc + 45);
        chk("rst_mid_no_frame", 32'(frames.size()), 0);
        chk("rst_mid_line_idle", 32'(uart_tx), 1);
        av_wr(16'h0001, 16'h00C3, w);
        acc = cyc;
        expect_frame("rst_after_byte", 8'hC3, f0);
        chk("rst_after_latency", 32'(f0.start - acc), 1);
        end_of_tx("rst_after", f0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/visor_trace_uart.md
VISOR_TRACE_UART -- requirements
Module: visor_trace_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving sysclk cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the FIFO entry count; a power of 2, 2..256.
REQ-003 SHALL have port sysclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sysreset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port av_address, input, 16 bits: Avalon-MM slave address from the visor master.
REQ-006 SHALL have port av_writedata, input, 16 bits: Avalon-MM write data.
REQ-007 SHALL have port av_write, input, 1 bit: Avalon-MM write strobe.
REQ-008 SHALL have port av_waitrequest, output, 1 bit: Avalon-MM stall.
REQ-009 SHALL have port uart_tx, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-010 SHALL have port fifo_count, output, 9 bits: number of occupied FIFO entries.
REQ-011 SHALL have port tx_busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.

Function
REQ-012 SHALL accept a write in any cycle where av_write=1 and av_waitrequest=0; the master holds all av_* signals while av_waitrequest=1.
REQ-013 SHALL decode only av_address[1:0]; bits [15:2] are ignored.
- 0: enqueue a word entry (send av_writedata[15:8], then av_writedata[7:0]).
- 1: enqueue a byte entry (send av_writedata[7:0] only).
- 2, 3: accept, no effect.
REQ-014 SHALL assert av_waitrequest combinationally = av_write AND FIFO full AND av_address[1]=0; a pop in the same cycle does not release it.
REQ-015 SHALL store one FIFO entry per accepted write as 17 bits {is_word, data}; fifo_count = entries stored and never exceeds FIFO_DEPTH.
REQ-016 SHALL read and write pointers wrap modulo FIFO_DEPTH; a simultaneous push and pop leaves fifo_count unchanged.
REQ-017 SHALL implement the transmit state machine with states IDLE, START, DATA, STOP.
REQ-018 SHALL in IDLE with fifo_count>0 pop the head entry in that cycle and enter START on the next cycle; uart_tx stays 1 during the pop cycle.
REQ-019 SHALL drive uart_tx=0 in START, data bits 0..7 in DATA, and 1 in STOP; each bit lasts exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
REQ-020 SHALL at the end of STOP for the high byte of a word go directly to START for the low byte with no idle cycle; otherwise go to IDLE.
REQ-021 SHALL keep the bit-period counter width at clog2(CLKS_PER_BIT); it counts from 0 to CLKS_PER_BIT-1 and then wraps.
REQ-022 SHALL drive tx_busy = (state≠IDLE) OR (fifo_count≠0).

Reset
REQ-023 SHALL on sysreset=1 at a clock edge set state=IDLE, uart_tx=1, pointers=0, fifo_count=0, bit counter=0, and tx_busy=0.
REQ-024 SHALL when reset occurs mid-frame abort the frame immediately; uart_tx is 1 from the next cycle and FIFO contents are discarded.
REQ-025 SHALL force av_waitrequest=0 while sysreset=1.

Structure
REQ-026 SHALL place the address decode constants (TRACE_ADDR_WORD=0, TRACE_ADDR_BYTE=1) and the state enum in the shared header package.
REQ-027 SHALL instantiate the FIFO as one sub-module, trace_fifo, parameterized by WIDTH=17 and DEPTH, with push, pop, full, empty and count.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 SHALL cover a word write to addr 0 of data 16'hA55A.
- uart_tx shows frames for 8'hA5 then 8'h5A, back-to-back.
- Total 80 cycles from the first start bit to the end of the second stop bit.
REQ-029 SHALL cover a byte write to addr 1 of data 16'h1234.
- Exactly one frame, byte 8'h34, then return to IDLE.
- tx_busy falls on the cycle after the stop bit ends.
REQ-030 SHALL cover five consecutive word writes.
- The first four are accepted and fifo_count reaches 4.
- The fifth sees av_waitrequest=1 until the first pop frees a slot, then is accepted.
- All five words are transmitted in order.
REQ-031 SHALL cover a write to addr 2 or addr 16'hFFFF with the FIFO full.
- Addr 2 is accepted with av_waitrequest=0 and fifo_count unchanged.
- Addr 16'hFFFF decodes as 3 and behaves identically.
REQ-032 SHALL cover sysreset asserted during the 3rd data bit of a frame.
- From the next cycle: uart_tx=1, fifo_count=0, tx_busy=0.
- A later write to addr 1 of 16'h00C3 transmits 8'hC3 correctly.
REQ-033 SHALL cover a push and a pop in the same cycle with fifo_count=2: fifo_count stays 2.
